// File: rtl/f32_to_rec_f32_seq.sv
// f32_to_rec_f32_seq: sequential IEEE binary32 to 33-bit recoded-format converter.
// Subnormals are normalised one bit per cycle in NORM before the result is presented.
module f32_to_rec_f32_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_in_valid,
    output logic        io_in_ready,
    input  logic [31:0] io_in_bits,
    output logic        io_out_valid,
    input  logic        io_out_ready,
    output logic [32:0] io_out_bits,
    output logic        io_busy
);
    typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

    state_t      state_q;
    logic        sign_q, valid_q, busy_q;
    logic [8:0]  x_q;
    logic [22:0] frac_q;
    logic [4:0]  nz_q;

    logic [7:0]  in_e;
    logic [22:0] in_f;
    logic        in_fire, e_zero, e_max, f_zero;
    logic [8:0]  in_x;

    assign in_e        = io_in_bits[30:23];
    assign in_f        = io_in_bits[22:0];
    assign e_zero      = in_e == 8'h00;
    assign e_max       = in_e == 8'hFF;
    assign f_zero      = in_f == 23'h0;
    assign io_in_ready = (state_q == IDLE) | ((state_q == DONE) & io_out_ready);
    assign in_fire     = io_in_valid & io_in_ready;
    assign in_x        = e_zero ? 9'h000 : e_max ? (f_zero ? 9'h180 : 9'h1C0) : {1'b0, in_e} + 9'h081;

    assign io_out_valid = valid_q;
    assign io_busy      = busy_q;
    assign io_out_bits  = {sign_q, x_q, frac_q};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            x_q     <= 9'h000;
            frac_q  <= 23'h0;
            nz_q    <= 5'd0;
        end else if (in_fire) begin
            sign_q <= io_in_bits[31];
            frac_q <= in_f;
            nz_q   <= 5'd0;
            if (e_zero & ~f_zero) begin
                state_q <= NORM;
                valid_q <= 1'b0;
                busy_q  <= 1'b1;
            end else begin
                state_q <= DONE;
                valid_q <= 1'b1;
                busy_q  <= 1'b0;
                x_q     <= in_x;
            end
        end else if (state_q == NORM) begin
            // Shifting out the leading one also drops the hidden bit.
            frac_q <= {frac_q[21:0], 1'b0};
            if (frac_q[22]) begin
                x_q     <= 9'h081 - {4'b0, nz_q};
                state_q <= DONE;
                valid_q <= 1'b1;
                busy_q  <= 1'b0;
            end else begin
                nz_q <= nz_q + 5'd1;
            end
        end else if ((state_q == DONE) & io_out_ready) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
        end
    end
endmodule
